// File: rtl/fm_stereo_blend.sv
// FM stereo matrix with pilot-qualified mono/stereo blending.
// A hysteresis FSM ramps the L-R gain between mono (0) and stereo (2^BLEND_LOG2).
module fm_stereo_blend #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned PILOT_WIDTH   = 32,
    parameter int unsigned BLEND_LOG2    = 6,
    parameter int unsigned LOCK_THRESH   = 1000,
    parameter int unsigned UNLOCK_THRESH = 500,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_lpr,
    input  logic [DATA_WIDTH-1:0]  in_lmr,
    input  logic                   pilot_valid,
    input  logic [PILOT_WIDTH-1:0] in_pilot,
    input  logic                   force_mono,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_left,
    output logic [DATA_WIDTH-1:0]  out_right,
    output logic                   stereo,
    output logic [1:0]             state
);

    localparam int unsigned G_W    = BLEND_LOG2 + 1;
    localparam int unsigned PROD_W = DATA_WIDTH + BLEND_LOG2 + 1;
    localparam int unsigned SUM_W  = DATA_WIDTH + 1;
    localparam int unsigned LC_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned UC_W   = $clog2(UNLOCK_COUNT + 1);

    localparam logic [G_W-1:0]         G_MAX    = G_W'(1 << BLEND_LOG2);
    localparam logic [PILOT_WIDTH-1:0] LOCK_T   = PILOT_WIDTH'(LOCK_THRESH);
    localparam logic [PILOT_WIDTH-1:0] UNLOCK_T = PILOT_WIDTH'(UNLOCK_THRESH);
    localparam logic [LC_W-1:0]        LOCK_N   = LC_W'(LOCK_COUNT);
    localparam logic [UC_W-1:0]        UNLOCK_N = UC_W'(UNLOCK_COUNT);

    localparam logic [1:0] ST_MONO    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_STEREO  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [G_W-1:0]         g;
    logic [G_W-1:0]         g_next;
    logic [G_W-1:0]         g_inc;
    logic [G_W-1:0]         g_dec;
    logic [1:0]             state_next;
    logic [LC_W-1:0]        lock_cnt;
    logic [LC_W-1:0]        lock_cnt_next;
    logic [LC_W-1:0]        lock_inc;
    logic [UC_W-1:0]        unlock_cnt;
    logic [UC_W-1:0]        unlock_cnt_next;
    logic [UC_W-1:0]        unlock_inc;
    logic                   lock_hit;
    logic                   unlock_hit;
    logic [PILOT_WIDTH-1:0] pilot_neg;
    logic [PILOT_WIDTH-1:0] pilot_mag;

    // Pilot magnitude; the most-negative code folds onto the largest positive value.
    always_comb begin
        pilot_neg = PILOT_WIDTH'(0) - in_pilot;
        if (!in_pilot[PILOT_WIDTH-1])
            pilot_mag = in_pilot;
        else if (pilot_neg[PILOT_WIDTH-1])
            pilot_mag = {1'b0, {(PILOT_WIDTH-1){1'b1}}};
        else
            pilot_mag = pilot_neg;
    end

    // Lock/unlock qualification counters, gain ramp and state selection.
    always_comb begin
        lock_cnt_next   = lock_cnt;
        unlock_cnt_next = unlock_cnt;
        lock_hit        = 1'b0;
        unlock_hit      = 1'b0;
        g_next          = g;
        state_next      = state;
        lock_inc   = (lock_cnt == LOCK_N) ? lock_cnt : lock_cnt + LC_W'(1);
        unlock_inc = (unlock_cnt == UNLOCK_N) ? unlock_cnt : unlock_cnt + UC_W'(1);
        g_inc      = (g == G_MAX) ? g : g + G_W'(1);
        g_dec      = (g == '0) ? g : g - G_W'(1);

        if (force_mono) begin
            lock_cnt_next = '0;
        end else if (pilot_valid) begin
            if (pilot_mag >= LOCK_T) begin
                lock_cnt_next = lock_inc;
                lock_hit      = (lock_inc == LOCK_N);
            end else begin
                lock_cnt_next = '0;
            end
        end

        if (pilot_valid) begin
            if (pilot_mag < UNLOCK_T) begin
                unlock_cnt_next = unlock_inc;
                unlock_hit      = (unlock_inc == UNLOCK_N);
            end else begin
                unlock_cnt_next = '0;
            end
        end

        case (state)
            ST_MONO:    g_next = '0;
            ST_ACQUIRE: if (in_valid) g_next = g_inc;
            ST_STEREO:  g_next = G_MAX;
            default:    if (in_valid) g_next = g_dec;
        endcase

        case (state)
            ST_MONO: begin
                if (lock_hit) state_next = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (force_mono || unlock_hit)
                    state_next = ST_RELEASE;
                else if (in_valid && (g_next == G_MAX))
                    state_next = ST_STEREO;
            end
            ST_STEREO: begin
                if (force_mono || unlock_hit) state_next = ST_RELEASE;
            end
            default: begin
                // lock_hit is already suppressed by force_mono and exclusive with unlock_hit
                if (lock_hit)
                    state_next = ST_ACQUIRE;
                else if (in_valid && (g_next == '0))
                    state_next = ST_MONO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_MONO;
            g          <= '0;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
            stereo     <= 1'b0;
        end else begin
            state      <= state_next;
            g          <= g_next;
            lock_cnt   <= lock_cnt_next;
            unlock_cnt <= unlock_cnt_next;
            stereo     <= (state_next == ST_STEREO);
        end
    end

    logic signed [PROD_W-1:0]  prod;
    logic [DATA_WIDTH-1:0]     lmr_s;
    logic                      s1_valid;
    logic [DATA_WIDTH-1:0]     s1_lpr;
    logic [DATA_WIDTH-1:0]     s1_lmr;
    logic signed [SUM_W-1:0]   sum_l;
    logic signed [SUM_W-1:0]   sum_r;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic [SUM_W-1:0] v);
        if (v[SUM_W-1] != v[SUM_W-2])
            return v[SUM_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return v[DATA_WIDTH-1:0];
    endfunction

    // Scaled L-R uses the gain before this sample's ramp step.
    always_comb begin
        prod  = PROD_W'($signed(in_lmr)) * PROD_W'($signed({1'b0, g}));
        lmr_s = DATA_WIDTH'(prod >>> BLEND_LOG2);
        sum_l = SUM_W'($signed(s1_lpr)) + SUM_W'($signed(s1_lmr));
        sum_r = SUM_W'($signed(s1_lpr)) - SUM_W'($signed(s1_lmr));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_lpr    <= '0;
            s1_lmr    <= '0;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_lpr <= in_lpr;
                s1_lmr <= lmr_s;
            end
            if (s1_valid) begin
                out_left  <= sat(sum_l);
                out_right <= sat(sum_r);
            end
        end
    end

endmodule
